gpio_in_cond: RTL
=================

Name: gpio_in_cond

Overview:
Input conditioning stage directly upstream of the GPIO bus peripheral. It takes 4 raw, asynchronous board inputs (switches/buttons) and drives the GPIO block's 4-bit gpio_in with synchronized, debounced levels. It also detects edges on the debounced levels and raises sticky per-channel interrupt flags for the interrupt controller.

Parameters:
PRESCALE, 16'd1000, clk cycles per debounce sample tick; legal 1..65535
DEB_CNT, 8'd4, consecutive differing sample ticks required to accept a new level; legal 1..255

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
pin_in  input  4  raw asynchronous pin levels
gpio_in  output  4  debounced levels; connects to the GPIO block's gpio_in
irq_rise_en  input  4  per-channel rising-edge interrupt enable
irq_fall_en  input  4  per-channel falling-edge interrupt enable
irq_clr  input  4  per-channel pending-flag clear, one-cycle pulse
irq_status  output  4  sticky per-channel pending flags
irq  output  1  OR of irq_status

Behaviour:
- Reset is synchronous and active-high on clk. While reset is asserted: sync flops=0, prescaler=0, per-channel counters=0, gpio_in=0, irq_status=0, irq=0.
- Reset asserted mid-debounce discards all partial counts.
- Synchronizer: 2-flop chain per channel; sync[i] is valid 2 clk edges after pin_in[i] changes.
- Prescaler:
  - 16-bit counter counts 0..PRESCALE-1, then wraps to 0.
  - tick=1 in the cycle where count==PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- Debounce, per channel i, with an 8-bit counter cnt[i]:
  - sync[i]==gpio_in[i]: cnt[i]<=0 every cycle, tick or not. Any bounce back restarts the count.
  - sync[i]!=gpio_in[i] and tick and cnt[i]==DEB_CNT-1: gpio_in[i]<=sync[i], cnt[i]<=0.
  - sync[i]!=gpio_in[i] and tick otherwise: cnt[i]<=cnt[i]+1.
  - sync[i]!=gpio_in[i] and no tick: cnt[i] holds.
- Latency from a stable pin_in change to gpio_in change is between 3+(DEB_CNT-1)*PRESCALE and 2+DEB_CNT*PRESCALE cycles, depending on prescaler phase. PRESCALE=1, DEB_CNT=1 gives exactly 3 cycles.
- Pulses on pin_in shorter than 1+(DEB_CNT-1)*PRESCALE cycles never reach gpio_in.
- Edge events:
  - rise[i] = gpio_in[i] updates 0->1; fall[i] = gpio_in[i] updates 1->0.
  - Each is a single-cycle event, evaluated in the same cycle as the update.
- Pending flags:
  - Set: irq_status[i]<=1 on the edge after (rise[i]&irq_rise_en[i]) | (fall[i]&irq_fall_en[i]).
  - Clear: irq_clr[i] clears irq_status[i].
  - Set and clear in the same cycle: set wins.
  - Clearing enables does not clear pending flags.
- irq = |irq_status. It is combinational from registers, with no extra latency.
- The 4 channels are fully independent and may update in the same cycle.

Optional Feature:
GPIO_IN_IRQ_EN
- Defined: edge detection, irq_status and irq behave as above.
- Undefined:
  - No edge or pending logic is built.
  - irq_status is tied to 4'b0 and irq to 0.
  - irq_rise_en, irq_fall_en and irq_clr remain as ports and are ignored.
  - Debounce path is unchanged.

Test Plan:
- Reset: hold reset 3 cycles with pin_in=4'hF -> gpio_in=0, irq_status=0, irq=0 during and on the first cycle after release.
- Basic latency (PRESCALE=1, DEB_CNT=1): pin_in 0->1 on ch0 -> gpio_in[0]=1 exactly 3 cycles later.
- Glitch rejection (PRESCALE=4, DEB_CNT=3): 5-cycle high pulse on ch1 -> gpio_in[1] stays 0. Then hold high -> gpio_in[1]=1 within 11..14 cycles.
- Bounce restart (PRESCALE=4, DEB_CNT=3): toggle ch2 high/low every 6 cycles for 60 cycles, then hold high -> gpio_in[2] stays 0 during toggling. It rises only after the final hold, within the 11..14-cycle latency window.
- Interrupt (macro on): irq_rise_en=4'h8, irq_fall_en=0, ch3 rises -> irq_status=4'h8 and irq=1 one cycle after gpio_in[3] rises. A ch3 fall sets nothing new. Pulse irq_clr=4'h8 -> irq_status=0, irq=0.
- Set/clear collision: irq_clr[3] pulsed in the same cycle as a qualifying ch3 edge -> irq_status[3]=1. With macro off, the same stimulus -> irq stays 0.

Source files
------------

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: 2-flop sync + prescaled debounce of 4 raw pins, with optional
// sticky edge interrupt flags built only when GPIO_IN_IRQ_EN is defined.
module gpio_in_cond #(
  parameter logic [15:0] PRESCALE = 16'd1000,
  parameter logic [7:0]  DEB_CNT  = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pin_in,
  output logic [3:0] gpio_in,
  input  logic [3:0] irq_rise_en,
  input  logic [3:0] irq_fall_en,
  input  logic [3:0] irq_clr,
  output logic [3:0] irq_status,
  output logic       irq
);
  logic [3:0]  s1, sync;
  logic [15:0] pcnt;
  logic        tick;
  logic [7:0]  cnt [4];
  assign tick = pcnt == PRESCALE - 16'd1;
  always_ff @(posedge clk)
    if (reset) begin
      s1   <= '0;
      sync <= '0;
      pcnt <= '0;
    end else begin
      s1   <= pin_in;
      sync <= s1;
      pcnt <= tick ? 16'd0 : pcnt + 16'd1;
    end
  // a level is accepted only after DEB_CNT consecutive ticks of disagreement
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (reset) begin
        cnt[i]     <= '0;
        gpio_in[i] <= 1'b0;
      end else if (sync[i] == gpio_in[i])
        cnt[i] <= '0;
      else if (tick && cnt[i] == DEB_CNT - 8'd1) begin
        gpio_in[i] <= sync[i];
        cnt[i]     <= '0;
      end else if (tick)
        cnt[i] <= cnt[i] + 8'd1;
`ifdef GPIO_IN_IRQ_EN
  logic [3:0] gpio_q, irq_set;
  assign irq_set = (gpio_in & ~gpio_q & irq_rise_en) | (~gpio_in & gpio_q & irq_fall_en);
  always_ff @(posedge clk)
    if (reset) begin
      gpio_q     <= '0;
      irq_status <= '0;
    end else begin
      gpio_q     <= gpio_in;
      irq_status <= (irq_status & ~irq_clr) | irq_set;
    end
  assign irq = |irq_status;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_rise_en, irq_fall_en, irq_clr};
  assign irq_status = 4'b0;
  assign irq        = 1'b0;
`endif
endmodule
